// File: rtl/ro_count_stats_pkg.sv
// Shared constants for the ring-oscillator count statistics block.
// Holds the FSM state codes so the top and any checkers agree on the encoding.
package ro_count_stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/ro_minmax.sv
// Combinational running-extrema update for one ring-oscillator count sample.
// Non-strict compares: an equal sample replaces the held value (same result either way).
module ro_minmax #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] cur_min_i,
    input  logic [DATA_WIDTH-1:0] cur_max_i,
    input  logic                  cur_dead_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic [DATA_WIDTH-1:0] nxt_min_o,
    output logic [DATA_WIDTH-1:0] nxt_max_o,
    output logic                  nxt_dead_o
);

    assign nxt_min_o  = (sample_i <= cur_min_i) ? sample_i : cur_min_i;
    assign nxt_max_o  = (sample_i >= cur_max_i) ? sample_i : cur_max_i;
    assign nxt_dead_o = cur_dead_i | (sample_i == '0);

endmodule

// File: rtl/ro_count_stats.sv
// Collects a configurable number of RO count samples and emits sum/min/max/range/dead.
// Handshakes: a beat moves when valid and ready are both high on a rising clock edge.
module ro_count_stats
    import ro_count_stats_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NS_WIDTH   = 8,
    parameter int SUM_WIDTH  = DATA_WIDTH + NS_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cfg_start,
    input  logic [NS_WIDTH-1:0]   cfg_nsamples,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_count,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_WIDTH-1:0]  out_sum,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_range,
    output logic                  out_dead,
    output logic                  busy,
    output state_t                dbg_state
);

    state_t                state_q;
    logic [NS_WIDTH-1:0]   nsamples_q;
    logic [NS_WIDTH-1:0]   cnt_q;
    logic [SUM_WIDTH-1:0]  sum_q;
    logic [DATA_WIDTH-1:0] min_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic [DATA_WIDTH-1:0] range_q;
    logic                  dead_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [SUM_WIDTH-1:0]  sum_d;
    logic [DATA_WIDTH-1:0] min_d;
    logic [DATA_WIDTH-1:0] max_d;
    logic                  dead_d;
    logic                  xfer;
    logic                  last;

    ro_minmax #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_minmax (
        .cur_min_i (min_q),
        .cur_max_i (max_q),
        .cur_dead_i(dead_q),
        .sample_i  (in_count),
        .nxt_min_o (min_d),
        .nxt_max_o (max_d),
        .nxt_dead_o(dead_d)
    );

    assign xfer  = in_ready_q & in_valid;
    assign sum_d = sum_q + SUM_WIDTH'(in_count);
    // nsamples of 0 wraps to all-ones, so the 2^NS_WIDTH-th sample is the last one.
    assign last  = (cnt_q == (nsamples_q - NS_WIDTH'(1)));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            nsamples_q  <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            range_q     <= '0;
            dead_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        state_q    <= ST_ACCUM;
                        nsamples_q <= cfg_nsamples;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        min_q      <= '1;
                        max_q      <= '0;
                        range_q    <= '0;
                        dead_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        sum_q  <= sum_d;
                        min_q  <= min_d;
                        max_q  <= max_d;
                        dead_q <= dead_d;
                        cnt_q  <= cnt_q + NS_WIDTH'(1);
                        if (last) begin
                            state_q     <= ST_EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            range_q     <= max_d - min_d;
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_range = range_q;
    assign out_dead  = dead_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ro_count_stats.sv
// Directed bench for ro_count_stats: a queue-based run model plus literal expectations.
module tb_ro_count_stats;
    import ro_count_stats_pkg::*;

    localparam int DW = 32;
    localparam int NW = 8;
    localparam int SW = DW + NW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [NW-1:0] cfg_nsamples = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_count = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic [DW-1:0] out_min;
    logic [DW-1:0] out_max;
    logic [DW-1:0] out_range;
    logic          out_dead;
    logic          busy;
    state_t        dbg_state;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ro_count_stats #(.DATA_WIDTH(DW), .NS_WIDTH(NW), .SUM_WIDTH(SW)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_nsamples(cfg_nsamples),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_min(out_min),
        .out_max(out_max), .out_range(out_range), .out_dead(out_dead), .busy(busy),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run model: 0 = idle, 1 = collecting, 2 = result pending.
    int            m_phase = 0;
    int            m_target = 0;
    logic [DW-1:0] m_q[$];
    logic [63:0]   m_sum = 0;
    logic [63:0]   m_min = 0;
    logic [63:0]   m_max = 0;
    logic [63:0]   m_range = 0;
    logic          m_dead = 1'b0;
    bit            m_fresh = 1'b1;

    task automatic model_results();
        m_sum = 0;
        m_min = {32'b0, {DW{1'b1}}};
        m_max = 0;
        m_dead = 1'b0;
        foreach (m_q[i]) begin
            m_sum += 64'(m_q[i]);
            if (64'(m_q[i]) < m_min) m_min = 64'(m_q[i]);
            if (64'(m_q[i]) > m_max) m_max = 64'(m_q[i]);
            if (m_q[i] == 0) m_dead = 1'b1;
        end
        m_range = m_max - m_min;
    endtask

    always @(posedge clock) begin
        if (!reset_n) begin
            m_phase = 0;
            m_q.delete();
            m_sum = 0; m_min = 0; m_max = 0; m_range = 0; m_dead = 1'b0;
            m_fresh = 1'b1;
        end else begin
            case (m_phase)
                0: if (cfg_start) begin
                    m_phase = 1;
                    m_target = (cfg_nsamples == 0) ? (1 << NW) : int'(cfg_nsamples);
                    m_q.delete();
                    m_fresh = 1'b0;
                end
                1: if (in_valid) begin
                    m_q.push_back(in_count);
                    if (m_q.size() == m_target) begin
                        model_results();
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_in_ready", in_ready, m_phase == 1);
            chk("cyc_out_valid", out_valid, m_phase == 2);
            chk("cyc_busy", busy, m_phase != 0);
            if (m_phase == 2 || m_fresh) begin
                chk("cyc_sum", out_sum, m_sum);
                chk("cyc_min", out_min, m_min);
                chk("cyc_max", out_max, m_max);
                chk("cyc_range", out_range, m_range);
                chk("cyc_dead", out_dead, m_dead);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic start_run(input int n);
        cfg_start = 1'b1;
        cfg_nsamples = n[NW-1:0];
        step();
        cfg_start = 1'b0;
    endtask

    // Leaves in_valid high so consecutive calls stream with no bubbles.
    task automatic send(input logic [DW-1:0] v, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_count = $urandom;
            step();
        end
        in_valid = 1'b1;
        in_count = v;
        t = 0;
        while (!in_ready && t < 100) begin
            step();
            t++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        step();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_count = $urandom;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            step();
            t++;
        end
        if (!out_valid) chk("out_timeout", 0, 1);
    endtask

    task automatic pop_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic check_result(input logic [63:0] s, input logic [63:0] mn, input logic [63:0] mx,
                                input logic [63:0] rg, input logic dd);
        chk("lit_sum", out_sum, s);
        chk("lit_min", out_min, mn);
        chk("lit_max", out_max, mx);
        chk("lit_range", out_range, rg);
        chk("lit_dead", out_dead, dd);
        chk("model_sum", m_sum, s);
        chk("model_min", m_min, mn);
        chk("model_range", m_range, rg);
        chk("emit_in_ready", in_ready, 0);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_min", out_min, 0);

        // Back-to-back run of four samples.
        start_run(4);
        chk("accum_state", dbg_state, ST_ACCUM);
        send(10, 0); send(7, 0); send(12, 0); send(7, 0);
        idle_in();
        wait_out();
        chk("emit_state", dbg_state, ST_EMIT);
        check_result(36, 7, 12, 5, 0);
        pop_out();
        chk("run1_idle_busy", busy, 0);

        // Gapped input and a stalled consumer.
        start_run(3);
        send(100, 2); send(50, 1); send(200, 3);
        idle_in();
        wait_out();
        check_result(350, 50, 200, 150, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_sum", out_sum, 350);
            step();
        end
        pop_out();
        chk("drop_valid", out_valid, 0);

        // nsamples=0 means 256 full-scale samples.
        start_run(0);
        for (int i = 0; i < 256; i++) send('1, 0);
        idle_in();
        wait_out();
        check_result(64'hFF_FFFF_FF00, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0, 0);
        pop_out();

        // Stalled oscillator sample.
        start_run(2);
        send(5, 0); send(0, 0);
        idle_in();
        wait_out();
        check_result(5, 0, 5, 5, 1);
        pop_out();

        // Reset mid-run discards the partial result.
        start_run(4);
        send(9, 0); send(9, 0);
        idle_in();
        step();
        do_reset();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_sum", out_sum, 0);
        start_run(4);
        send(1, 0); send(1, 0); send(1, 0); send(1, 0);
        idle_in();
        wait_out();
        check_result(4, 1, 1, 0, 0);
        pop_out();

        // cfg_start outside IDLE is ignored.
        start_run(3);
        send(3, 0);
        cfg_start = 1'b1;
        cfg_nsamples = 1;
        send(4, 0);
        cfg_start = 1'b0;
        send(5, 0);
        idle_in();
        wait_out();
        check_result(12, 3, 5, 2, 0);
        cfg_start = 1'b1;
        cfg_nsamples = 2;
        pop_out();
        cfg_start = 1'b0;
        chk("ign_busy", busy, 0);
        chk("ign_in_ready", in_ready, 0);
        step();
        chk("ign_state", dbg_state, ST_IDLE);
        chk("ign_busy2", busy, 0);
        step();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_count_stats.md
RO_COUNT_STATS -- requirements
Module: ro_count_stats

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one ring-oscillator count sample.
REQ-002 Parameter NS_WIDTH, default 8: width of the sample-count configuration.
REQ-003 Parameter SUM_WIDTH, default DATA_WIDTH+NS_WIDTH: width of the accumulated sum.
REQ-004 clock  input  1: single clock; all logic SHALL be rising-edge triggered on it.
REQ-005 reset_n  input  1: reset, synchronous and active-low.
REQ-006 cfg_start  input  1: single-cycle pulse that starts one statistics run.
REQ-007 cfg_nsamples  input  NS_WIDTH: samples per run; 0 SHALL mean 2^NS_WIDTH.
REQ-008 in_valid  input  1: upstream count sample is valid.
REQ-009 in_ready  output  1: block accepts a sample this cycle.
REQ-010 in_count  input  DATA_WIDTH: count value from the RO measurement stage.
REQ-011 out_valid  output  1: result bundle is valid.
REQ-012 out_ready  input  1: consumer accepts the result bundle.
REQ-013 out_sum  output  SUM_WIDTH: sum of all samples in the run.
REQ-014 out_min  output  DATA_WIDTH: smallest sample in the run.
REQ-015 out_max  output  DATA_WIDTH: largest sample in the run.
REQ-016 out_range  output  DATA_WIDTH: out_max minus out_min.
REQ-017 out_dead  output  1: at least one sample in the run equalled 0 (stalled oscillator).
REQ-018 busy  output  1: high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ACCUM and EMIT.
REQ-020 IDLE->ACCUM on cfg_start=1; this edge SHALL latch cfg_nsamples, clear sum, load min to all-ones, clear max and clear dead.
REQ-021 in_ready SHALL be 1 only in ACCUM; a transfer SHALL occur on in_valid=1 and in_ready=1 in the same cycle.
REQ-022 Each transfer SHALL add in_count to sum, update min and max with non-strict compares, OR (in_count==0) into dead, and increment the sample counter.
REQ-023 ACCUM->EMIT SHALL occur on the transfer that completes the latched count; out_valid SHALL rise on the next cycle, with no further samples accepted.
REQ-024 In EMIT, out_valid SHALL stay high and the outputs SHALL stay stable until out_ready=1; EMIT->IDLE SHALL occur on that cycle.
REQ-025 out_range SHALL be registered and valid whenever out_valid=1.
REQ-026 The sum SHALL never overflow: SUM_WIDTH holds 2^NS_WIDTH samples of full-scale value.
REQ-027 cfg_start SHALL be ignored outside IDLE, including the EMIT cycle in which out_ready=1.
REQ-028 With in_valid held high, the block SHALL accept one sample per cycle (no bubbles).
REQ-029 in_count SHALL be sampled only on a transfer cycle; values outside transfer cycles SHALL have no effect.

Reset
REQ-030 reset_n=0 on a clock edge SHALL force IDLE, in_ready=0, out_valid=0, busy=0, out_sum=0, out_min=0, out_max=0, out_range=0 and out_dead=0.
REQ-031 Reset during ACCUM or EMIT SHALL discard the partial or pending result without emitting it.

Structure
REQ-032 State codes IDLE/ACCUM/EMIT SHALL be defined in the team's shared constants header, not locally.
REQ-033 The min/max/dead update SHALL be a sub-module, ro_minmax, that is purely combinational on the current extrema and the sample; the sum and counter SHALL stay in the top level.

Verification
REQ-034 Run nsamples=4, counts 10,7,12,7 back-to-back -> out_sum=36, out_min=7, out_max=12, out_range=5, out_dead=0.
REQ-035 Run nsamples=3 with in_valid gaps and out_ready held low for 5 cycles -> out_valid stays high with stable outputs, then drops the cycle after out_ready=1.
REQ-036 nsamples=0 with 256 samples of 0xFFFFFFFF -> out_sum=0xFFFFFFFF00, out_min=out_max=0xFFFFFFFF, out_range=0.
REQ-037 Run nsamples=2, counts 5,0 -> out_dead=1, out_min=0, out_range=5.
REQ-038 Reset asserted after 2 of 4 samples, then a fresh run of 1,1,1,1 -> no stale out_valid and out_sum=4.
REQ-039 cfg_start pulsed during ACCUM and on the EMIT/out_ready cycle -> ignored, and the block returns to IDLE with busy=0.
